// File: rtl/act_pkg.sv
// Shared definitions for the activation unit: mode and FSM encodings plus
// sign-magnitude field helpers.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_SOFTSIGN = 2'b00,
    ACT_RELU     = 2'b01,
    ACT_PASS     = 2'b10,
    ACT_RSVD     = 2'b11
  } act_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_POST,
    ST_DONE
  } act_state_e;

  // Sign bit of a w-bit sign-magnitude value carried in a 64-bit container.
  function automatic logic sm_sign(input logic [63:0] x, input int w);
    return x[w-1];
  endfunction

  // Magnitude field (bits w-2:0) of a w-bit sign-magnitude value.
  function automatic logic [63:0] sm_to_mag(input logic [63:0] x, input int w);
    return x & ((64'd1 << (w - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/activation_vec_if.sv
// Vector valid/ready bus between the MAC accumulator, the activation unit and
// the next layer.
interface activation_vec_if #(
  parameter int W   = 16,
  parameter int NCH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [NCH*W-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [NCH*W-1:0] out_vec;

  modport master (
    output in_valid, mode, in_vec, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, mode, in_vec, out_ready,
    output in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/act_div_seq.sv
// Restoring unsigned divider: 2W-bit numerator over W-bit denominator, one
// quotient bit per cycle. The first step happens on the start edge, so done
// rises exactly W cycles after start and quot holds until the next start.
// The caller guarantees num[2W-1:W] < den so the quotient fits in W bits.
module act_div_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           start,
  input  logic [2*W-1:0] num,
  input  logic [W-1:0]   den,
  output logic           done,
  output logic [W-1:0]   quot
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  den_q, den_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // One restoring step: shift the next numerator bit into the remainder,
  // subtract when possible, and shift the quotient bit into the low end.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                               input logic [W-1:0] sh,
                                               input logic [W-1:0] dv);
    logic [W:0] trial;
    trial = {rem, sh[W-1]};
    if (trial >= {1'b0, dv}) return {W'(trial - {1'b0, dv}), sh[W-2:0], 1'b1};
    else                     return {trial[W-1:0], sh[W-2:0], 1'b0};
  endfunction

  // Next-state: load and first step on start, then iterate until count runs out.
  always_comb begin
    rem_d  = rem_q;
    sh_d   = sh_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (start) begin
      {rem_d, sh_d} = div_step(num[2*W-1:W], num[W-1:0], den);
      den_d  = den;
      cnt_d  = CW'(W - 1);
      done_d = 1'b0;
    end else if (cnt_q != '0) begin
      {rem_d, sh_d} = div_step(rem_q, sh_q, den_q);
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
    end
  end

  // Divider state; frozen while en is low, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      sh_q   <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      rem_q  <= rem_d;
      sh_q   <= sh_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign quot = sh_q;

endmodule

// File: rtl/activation_vec.sv
// Multi-channel activation unit: offset softsign, ReLU or pass-through on a
// vector of sign-magnitude values. Channels are processed one at a time, and
// softsign channels share a single iterative divider.
module activation_vec
  import act_pkg::*;
#(
  parameter int             W      = 16,
  parameter int             FRAC   = 8,
  parameter int             NCH    = 4,
  parameter logic [W-1:0]   OFFSET = 16'h0080
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  activation_vec_if.slave  io,
  output logic             busy
);
  localparam int           CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;

  act_state_e       state_q, state_d;
  act_mode_e        mode_q, mode_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [NCH*W-1:0] in_vec_q, in_vec_d;
  logic [NCH*W-1:0] out_vec_q, out_vec_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [W-1:0]     cur, cur_mag, div_den, div_quot;
  logic [2*W-1:0]   div_num;
  logic             div_start, div_done;

  // Activation of one channel given its divider quotient q = floor((m<<FRAC)/(m+ONE)).
  // A zero magnitude always leaves with a positive sign.
  function automatic logic [W-1:0] activate(input act_mode_e md,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] q);
    logic         s, neg;
    logic [W-1:0] m, off, mag;
    s   = sm_sign(64'(x), W);
    m   = W'(sm_to_mag(64'(x), W));
    off = {1'b0, OFFSET[W-2:0]};
    neg = 1'b0;
    mag = m;
    case (md)
      ACT_SOFTSIGN: begin
        if (!s)             mag = off + q;
        else if (off >= q)  mag = off - q;
        else begin
          mag = q - off;
          neg = 1'b1;
        end
      end
      ACT_RELU: if (s) mag = '0;
      default:  neg = s;
    endcase
    if (mag == '0) neg = 1'b0;
    return {neg, mag[W-2:0]};
  endfunction

  // Current channel operands for the shared divider.
  always_comb begin
    cur       = in_vec_q[ch_q*W +: W];
    cur_mag   = W'(sm_to_mag(64'(cur), W));
    div_num   = {{W{1'b0}}, cur_mag} << FRAC;
    div_den   = cur_mag + ONE;
    div_start = (state_q == ST_LOAD) && (mode_q == ACT_SOFTSIGN);
  end

  act_div_seq #(.W(W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .quot  (div_quot)
  );

  // Transaction FSM: accept, walk the channels LOAD/DIV/POST, hold result in DONE.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ch_d      = ch_q;
    in_vec_d  = in_vec_q;
    out_vec_d = out_vec_q;
    case (state_q)
      ST_IDLE: begin
        if (io.in_valid && in_ready_q) begin
          in_vec_d = io.in_vec;
          mode_d   = act_mode_e'(io.mode);
          ch_d     = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: state_d = (mode_q == ACT_SOFTSIGN) ? ST_DIV : ST_POST;
      ST_DIV:  if (div_done) state_d = ST_POST;
      ST_POST: begin
        out_vec_d[ch_q*W +: W] = activate(mode_q, cur, div_quot);
        if (ch_q == CHW'(NCH - 1)) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: if (io.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Control and output registers; everything holds while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= ACT_SOFTSIGN;
      ch_q        <= '0;
      out_vec_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ch_q        <= ch_d;
      out_vec_q   <= out_vec_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Latched input vector; only meaningful after an accept, so no reset.
  always_ff @(posedge clk) begin
    if (en) in_vec_q <= in_vec_d;
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_vec   = out_vec_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_activation_vec.sv
// Bench for activation_vec: directed cases from the block description plus
// randomized vectors checked against an arithmetic reference model.
module tb_activation_vec;
  localparam int W      = 16;
  localparam int FRAC   = 8;
  localparam int NCH    = 4;
  localparam int OFFSET = 'h80;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic busy;

  activation_vec_if #(.W(W), .NCH(NCH)) bus ();

  activation_vec #(.W(W), .FRAC(FRAC), .NCH(NCH), .OFFSET(16'h0080)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .io   (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] c0, input logic [15:0] c1,
                                     input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Reference: activation computed with plain integer arithmetic.
  function automatic logic [15:0] model_ch(input logic [1:0] md, input logic [15:0] x);
    int m, q, v;
    bit s;
    m = int'(x[14:0]);
    s = x[15];
    if (md == 2'b00) begin
      q = (m * (1 << FRAC)) / (m + (1 << FRAC));
      v = s ? OFFSET - q : OFFSET + q;
      if (v < 0) return 16'h8000 | 16'(-v);
      return 16'(v);
    end else if (md == 2'b01) begin
      return (s || m == 0) ? 16'h0000 : x;
    end
    return (m == 0) ? 16'h0000 : x;
  endfunction

  function automatic logic [63:0] model_vec(input logic [1:0] md, input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = model_ch(md, v[k*W +: W]);
    return r;
  endfunction

  // Present one vector, then count edges from the accept edge (inclusive) to the
  // edge that raises out_valid. en is dropped for 5 edges starting at gap_at.
  task automatic run_txn(input logic [1:0] md, input logic [63:0] vec, input int gap_at,
                         output int lat);
    int k;
    k = 0;
    while (!bus.in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.mode     = md;
    bus.in_vec   = vec;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", bus.in_ready, 0);
    lat = 1;
    while (!bus.out_valid && lat < 400) begin
      en = (gap_at == 0 || lat < gap_at || lat >= gap_at + 5);
      @(posedge clk); #1;
      lat++;
    end
    en = 1'b1;
    check("out_valid_arrives", bus.out_valid, 1);
  endtask

  task automatic finish_txn();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_handshake", bus.out_valid, 0);
    check("busy_after_handshake", busy, 0);
    check("in_ready_after_handshake", bus.in_ready, 1);
  endtask

  initial begin
    int          lat;
    logic [63:0] va, vb, snap, vr;
    logic [1:0]  md;
    bit          stable;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 2'b00;
    bus.in_vec    = '0;

    // Reset state
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_vec", bus.out_vec, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", bus.in_ready, 1);

    // Softsign basic
    va = pk(16'h0100, 16'h8100, 16'h0300, 16'h8300);
    run_txn(2'b00, va, 0, lat);
    check("softsign_latency", 64'(lat), 73);
    check("softsign_basic", bus.out_vec, pk(16'h0100, 16'h0000, 16'h0140, 16'h8040));
    finish_txn();

    // Softsign extremes
    run_txn(2'b00, pk(16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF), 0, lat);
    check("softsign_extremes", bus.out_vec, pk(16'h0080, 16'h0080, 16'h017E, 16'h807E));
    finish_txn();

    // ReLU
    vb = pk(16'h8100, 16'h0280, 16'h8000, 16'h7FFF);
    run_txn(2'b01, vb, 0, lat);
    check("relu_latency", 64'(lat), 9);
    check("relu_vec", bus.out_vec, pk(16'h0000, 16'h0280, 16'h0000, 16'h7FFF));
    finish_txn();

    // Pass and reserved mode
    run_txn(2'b10, vb, 0, lat);
    check("pass_latency", 64'(lat), 9);
    check("pass_vec", bus.out_vec, pk(16'h8100, 16'h0280, 16'h0000, 16'h7FFF));
    finish_txn();
    run_txn(2'b11, vb, 0, lat);
    check("rsvd_vec", bus.out_vec, pk(16'h8100, 16'h0280, 16'h0000, 16'h7FFF));
    finish_txn();

    // Backpressure: result held 20 cycles while a new vector waits
    run_txn(2'b00, va, 0, lat);
    bus.in_valid = 1'b1;
    bus.mode     = 2'b01;
    bus.in_vec   = vb;
    snap   = bus.out_vec;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_vec !== snap || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          busy !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 1);
    check("bp_vec", bus.out_vec, pk(16'h0100, 16'h0000, 16'h0140, 16'h8040));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_release_out_valid", bus.out_valid, 0);
    run_txn(2'b01, vb, 0, lat);
    check("bp_next_latency", 64'(lat), 9);
    check("bp_next_vec", bus.out_vec, pk(16'h0000, 16'h0280, 16'h0000, 16'h7FFF));
    finish_txn();

    // Enable gap of 5 cycles during the first divide
    run_txn(2'b00, va, 10, lat);
    check("en_gap_latency", 64'(lat), 78);
    check("en_gap_vec", bus.out_vec, pk(16'h0100, 16'h0000, 16'h0140, 16'h8040));
    finish_txn();

    // Reset during the divide of channel 2
    bus.in_valid = 1'b1;
    bus.mode     = 2'b00;
    bus.in_vec   = va;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_vec", bus.out_vec, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", bus.in_ready, 1);
    run_txn(2'b00, va, 0, lat);
    check("midrst_next_latency", 64'(lat), 73);
    check("midrst_next_vec", bus.out_vec, pk(16'h0100, 16'h0000, 16'h0140, 16'h8040));
    finish_txn();

    // Randomized vectors against the reference model
    for (int t = 0; t < 12; t++) begin
      md = 2'($urandom_range(0, 3));
      vr = '0;
      for (int k = 0; k < NCH; k++) begin
        case ($urandom_range(0, 7))
          0:       vr[k*W +: W] = 16'h8000;
          1:       vr[k*W +: W] = 16'h0000;
          2:       vr[k*W +: W] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h7FFF;
          default: vr[k*W +: W] = 16'($urandom);
        endcase
      end
      run_txn(md, vr, 0, lat);
      check("rand_latency", 64'(lat), (md == 2'b00) ? 64'd73 : 64'd9);
      check("rand_vec", bus.out_vec, model_vec(md, vr));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      finish_txn();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
